// File: rtl/usb_pll_ctrl.sv
// USB PLL bring-up/supervision: reset pulse, lock wait with timeout, stability qualification,
// retries over a fixed ICP/LPF table. Optional macro USB_PLL_CTRL_RELOCK_EN re-sequences on lock loss.
module usb_pll_ctrl #(
  parameter int RST_CYCLES    = 48,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int STABLE_CYCLES = 240,
  parameter int MAX_TRIES     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_icpsel,
  output logic [2:0] pll_lpfres,
  output logic [1:0] pll_lpfcap,
  output logic       ready,
  output logic       busy,
  output logic       fail,
  output logic [1:0] try_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WAIT, S_STAB, S_RETRY, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] ST_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [1:0]  TRY_LAST = 2'(MAX_TRIES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  try_nxt;
  logic        load_set;
  logic        lock_p0, lock_s;

  // {icpsel, lpfres, lpfcap} per try index
  function automatic logic [10:0] settings_of(input logic [1:0] idx);
    case (idx)
      2'd0:    settings_of = {6'd16, 3'd2, 2'd0};
      2'd1:    settings_of = {6'd24, 3'd3, 2'd0};
      2'd2:    settings_of = {6'd12, 3'd1, 2'd1};
      default: settings_of = {6'd32, 3'd4, 2'd1};
    endcase
  endfunction

  // Stage p0/s: two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_s  <= lock_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    try_nxt   = try_idx;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_RST;
          try_nxt   = 2'd0;
        end
        S_RST:   if (cnt == RST_LAST) state_nxt = S_WAIT;
        S_WAIT: begin
          if (lock_s)              state_nxt = S_STAB;
          else if (cnt == TO_LAST) state_nxt = S_RETRY;
        end
        S_STAB: begin
          if (!lock_s)             state_nxt = S_RETRY;
          else if (cnt == ST_LAST) state_nxt = S_LOCKED;
        end
        S_RETRY: begin
          if (try_idx == TRY_LAST) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_RST;
            try_nxt   = try_idx + 2'd1;
          end
        end
        S_LOCKED: begin
          if (!lock_s) begin
`ifdef USB_PLL_CTRL_RELOCK_EN
            state_nxt = S_RST;
            try_nxt   = 2'd0;
`else
            state_nxt = S_FAIL;
`endif
          end
        end
        S_FAIL:  state_nxt = S_FAIL;
        default: state_nxt = S_IDLE;
      endcase
    end

    // Counter restarts on every state entry and only runs in timed states
    cnt_nxt = cnt;
    if (state_nxt != state)
      cnt_nxt = 16'd0;
    else if (state == S_RST || state == S_WAIT || state == S_STAB)
      cnt_nxt = cnt + 16'd1;

    load_set = (state_nxt == S_RST) && (state != S_RST);
  end

  // Stage state: state, counter and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 16'd0;
      try_idx    <= 2'd0;
      pll_reset  <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
      {pll_icpsel, pll_lpfres, pll_lpfcap} <= settings_of(2'd0);
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      try_idx   <= try_nxt;
      pll_reset <= !(state_nxt == S_WAIT || state_nxt == S_STAB || state_nxt == S_LOCKED);
      ready     <= (state_nxt == S_LOCKED);
      busy      <= (state_nxt == S_RST || state_nxt == S_WAIT ||
                    state_nxt == S_STAB || state_nxt == S_RETRY);
      fail      <= (state_nxt == S_FAIL);
      if (load_set)
        {pll_icpsel, pll_lpfres, pll_lpfcap} <= settings_of(try_nxt);
    end
  end

endmodule

// File: tb/tb_usb_pll_ctrl.sv
// Self-checking bench for usb_pll_ctrl with shortened timing parameters and randomized lock timing.
module tb_usb_pll_ctrl;

  localparam int R = 8;
  localparam int T = 60;
  localparam int S = 20;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_icpsel;
  logic [2:0] pll_lpfres;
  logic [1:0] pll_lpfcap;
  logic       ready, busy, fail;
  logic [1:0] try_idx;

  int checks = 0;
  int passes = 0;

  int icp_t [4] = '{16, 24, 12, 32};
  int res_t [4] = '{2, 3, 1, 4};
  int cap_t [4] = '{0, 0, 1, 1};

  usb_pll_ctrl #(.RST_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S), .MAX_TRIES(M)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_icpsel(pll_icpsel), .pll_lpfres(pll_lpfres),
    .pll_lpfcap(pll_lpfcap), .ready(ready), .busy(busy), .fail(fail), .try_idx(try_idx)
  );

  always #5 clk = ~clk;

  // Settings may only move while the PLL is held in reset
  logic [10:0] prev_set = 11'd0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && {pll_icpsel, pll_lpfres, pll_lpfcap} !== prev_set) begin
      checks++;
      if (pll_reset !== 1'b1)
        $display("FAIL settings_change_in_reset: pll_reset=%b required 1", pll_reset);
      else
        passes++;
    end
    prev_set = {pll_icpsel, pll_lpfres, pll_lpfcap};
  end

  // Expected edge counts derived from the timing rules
  function automatic int exp_rst_release();     return R + 1;                  endfunction
  function automatic int exp_ready_after_lock(); return S + 3;                 endfunction
  function automatic int exp_exhaust();          return M * (R + T + 1) + 1;   endfunction

  // Counts edges until sel-signal equals val (sampled on negedge); -1 on timeout
  task automatic wait_for(input int sel, input logic val, input int bound, output int n);
    logic s;
    n = 0;
    s = ~val;
    while (s !== val && n < bound) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      case (sel)
        0:       s = pll_reset;
        1:       s = ready;
        2:       s = fail;
        default: s = busy;
      endcase
    end
    if (s !== val) n = -1;
  endtask

  task automatic idle_all();
    @(posedge clk); #1;
    en = 1'b0;
    pll_lock = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pll_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pll_reset, ready, busy, fail, try_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0})
      $display("FAIL reset_ctrl: rst/rdy/busy/fail/try=%b%b%b%b%0d required 10000",
               pll_reset, ready, busy, fail, try_idx);
    else passes++;
    checks++;
    if (pll_icpsel !== 6'(icp_t[0]) || pll_lpfres !== 3'(res_t[0]) || pll_lpfcap !== 2'(cap_t[0]))
      $display("FAIL reset_settings: got %0d/%0d/%0d required 16/2/0", pll_icpsel, pll_lpfres, pll_lpfcap);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nominal_and_loss();
    int n, l;
    l = $urandom_range(0, T - 4);
    @(posedge clk); #1;
    en = 1'b1;
    wait_for(0, 1'b0, 500, n);
    checks++;
    if (n != exp_rst_release()) $display("FAIL nominal_rst_width: %0d edges required %0d", n, exp_rst_release());
    else passes++;
    repeat (l) @(posedge clk);
    #1 pll_lock = 1'b1;
    wait_for(1, 1'b1, 500, n);
    checks++;
    if (n != exp_ready_after_lock()) $display("FAIL nominal_ready_delay: %0d edges required %0d (L=%0d)", n, exp_ready_after_lock(), l);
    else passes++;
    checks++;
    if (try_idx !== 2'd0 || busy !== 1'b0 || pll_reset !== 1'b0 || pll_icpsel !== 6'(icp_t[0]) ||
        pll_lpfres !== 3'(res_t[0]) || pll_lpfcap !== 2'(cap_t[0]))
      $display("FAIL nominal_locked_outputs: try=%0d busy=%b rst=%b icp=%0d required 0 0 0 16", try_idx, busy, pll_reset, pll_icpsel);
    else passes++;
    @(posedge clk); #1;
    pll_lock = 1'b0;
    wait_for(1, 1'b0, 50, n);
    checks++;
    if (n != 3) $display("FAIL loss_ready_drop: %0d edges required 3", n);
    else passes++;
`ifdef USB_PLL_CTRL_RELOCK_EN
    checks++;
    if (busy !== 1'b1 || pll_reset !== 1'b1 || try_idx !== 2'd0 || fail !== 1'b0)
      $display("FAIL loss_relock: busy=%b rst=%b try=%0d fail=%b required 1 1 0 0", busy, pll_reset, try_idx, fail);
    else passes++;
`else
    checks++;
    if (fail !== 1'b1 || pll_reset !== 1'b1 || busy !== 1'b0)
      $display("FAIL loss_fail: fail=%b rst=%b busy=%b required 1 1 0", fail, pll_reset, busy);
    else passes++;
`endif
    idle_all();
  endtask

  task automatic test_retry();
    int n, k, l;
    k = $urandom_range(1, M - 1);
    l = $urandom_range(0, T - 4);
    @(posedge clk); #1;
    en = 1'b1;
    wait_for(0, 1'b0, 500, n);
    for (int i = 0; i < k; i++) begin
      wait_for(0, 1'b1, 500, n);
      checks++;
      if (n != T || busy !== 1'b1) $display("FAIL retry_timeout_%0d: %0d edges busy=%b required %0d 1", i, n, busy, T);
      else passes++;
      wait_for(0, 1'b0, 500, n);
      checks++;
      if (n != R + 1) $display("FAIL retry_reset_gap_%0d: %0d edges required %0d", i, n, R + 1);
      else passes++;
      checks++;
      if (try_idx !== 2'(i + 1) || pll_icpsel !== 6'(icp_t[i+1]) || pll_lpfres !== 3'(res_t[i+1]) ||
          pll_lpfcap !== 2'(cap_t[i+1]))
        $display("FAIL retry_entry_%0d: try=%0d set=%0d/%0d/%0d required %0d %0d/%0d/%0d", i, try_idx,
                 pll_icpsel, pll_lpfres, pll_lpfcap, i + 1, icp_t[i+1], res_t[i+1], cap_t[i+1]);
      else passes++;
    end
    repeat (l) @(posedge clk);
    #1 pll_lock = 1'b1;
    wait_for(1, 1'b1, 500, n);
    checks++;
    if (n != exp_ready_after_lock() || try_idx !== 2'(k))
      $display("FAIL retry_ready: %0d edges try=%0d required %0d %0d", n, try_idx, exp_ready_after_lock(), k);
    else passes++;
    idle_all();
  endtask

  task automatic test_exhaustion();
    int n;
    @(posedge clk); #1;
    en = 1'b1;
    wait_for(2, 1'b1, 2000, n);
    checks++;
    if (n != exp_exhaust()) $display("FAIL exhaust_time: %0d edges required %0d", n, exp_exhaust());
    else passes++;
    checks++;
    if (pll_reset !== 1'b1 || busy !== 1'b0 || ready !== 1'b0 || try_idx !== 2'(M - 1))
      $display("FAIL exhaust_outputs: rst=%b busy=%b rdy=%b try=%0d required 1 0 0 %0d", pll_reset, busy, ready, try_idx, M - 1);
    else passes++;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (fail !== 1'b1) $display("FAIL exhaust_sticky: fail=%b required 1", fail);
    else passes++;
    en = 1'b0;
    wait_for(2, 1'b0, 10, n);
    checks++;
    if (n != 1 || pll_reset !== 1'b1) $display("FAIL exhaust_clear: %0d edges rst=%b required 1 1", n, pll_reset);
    else passes++;
    idle_all();
  endtask

  task automatic test_glitch();
    int n, l, g;
    l = $urandom_range(0, T - 4);
    g = $urandom_range(1, S - 2);
    @(posedge clk); #1;
    en = 1'b1;
    wait_for(0, 1'b0, 500, n);
    repeat (l) @(posedge clk);
    #1 pll_lock = 1'b1;
    repeat (g) @(posedge clk);
    #1 pll_lock = 1'b0;
    @(posedge clk);
    #1 pll_lock = 1'b1;
    wait_for(0, 1'b1, 50, n);
    checks++;
    if (n != 2 || ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL glitch_retry: %0d edges rdy=%b busy=%b required 2 0 1 (L=%0d G=%0d)", n, ready, busy, l, g);
    else passes++;
    wait_for(0, 1'b0, 500, n);
    checks++;
    if (n != R + 1 || try_idx !== 2'd1 || pll_icpsel !== 6'(icp_t[1]))
      $display("FAIL glitch_next_entry: %0d edges try=%0d icp=%0d required %0d 1 %0d", n, try_idx, pll_icpsel, R + 1, icp_t[1]);
    else passes++;
    wait_for(1, 1'b1, 500, n);
    checks++;
    if (n != S + 1) $display("FAIL glitch_ready_delay: %0d edges required %0d", n, S + 1);
    else passes++;
    idle_all();
  endtask

  task automatic test_en_abort();
    int n, a;
    a = $urandom_range(2, R + T / 2);
    @(posedge clk); #1;
    en = 1'b1;
    if (a > R + 2) pll_lock = 1'b1;
    repeat (a) @(posedge clk);
    #1 en = 1'b0;
    wait_for(3, 1'b0, 10, n);
    checks++;
    if (n != 1 || pll_reset !== 1'b1 || ready !== 1'b0 || fail !== 1'b0)
      $display("FAIL en_abort: %0d edges rst=%b rdy=%b fail=%b required 1 1 0 0 (a=%0d)", n, pll_reset, ready, fail, a);
    else passes++;
    idle_all();
  endtask

  task automatic test_async_reset();
    int n;
    @(posedge clk); #1;
    en = 1'b1;
    wait_for(0, 1'b0, 500, n);
    repeat ($urandom_range(1, T - 5)) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (pll_reset !== 1'b1 || busy !== 1'b0 || try_idx !== 2'd0 || pll_icpsel !== 6'(icp_t[0]))
      $display("FAIL async_reset: rst=%b busy=%b try=%0d icp=%0d required 1 0 0 16", pll_reset, busy, try_idx, pll_icpsel);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_for(0, 1'b0, 500, n);
    checks++;
    if (n != exp_rst_release() || try_idx !== 2'd0)
      $display("FAIL async_restart: %0d edges try=%0d required %0d 0", n, try_idx, exp_rst_release());
    else passes++;
    idle_all();
  endtask

  initial begin
    test_reset();
    test_nominal_and_loss();
    for (int r = 0; r < 3; r++) test_retry();
    test_exhaustion();
    for (int r = 0; r < 3; r++) test_glitch();
    for (int r = 0; r < 3; r++) test_en_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
